ysyx_23060201_lsu: RTL and testbench

Load/store unit directly upstream of the data-memory stage. It accepts one memory instruction at a time from EXU over a valid/ready handshake and aligns the address. It builds the byte mask and lane-shifted store data driving mem_wen/mem_waddr/mem_wdata/mem_wmask. For loads, it issues a word read, extracts and sign- or zero-extends the addressed lane, and returns the result to WBU over a second valid/ready handshake.

---
 rtl/ysyx_23060201_lsu.sv | 172 +++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one request at a time from EXU, byte-lane alignment for stores and
// sign/zero extension for loads. Optional macro YSYX_23060201_LSU_ALIGN_CHECK_EN traps misaligned h/w.
module ysyx_23060201_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wen,
   input  logic                  in_ren,
   input  logic [2:0]            in_funct3,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   input  logic [4:0]            in_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_rdata,
   output logic [4:0]            out_rd,
   output logic                  out_err,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [7:0]            mem_wmask,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, STORE, LOAD, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [2:0]            funct3_q;
   logic [4:0]            rd_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  inIllegal;
   logic                  inMisalign;
   logic                  inErr;
   logic [1:0]            effOff;
   logic [DATA_WIDTH-1:0] loadShift;
   logic [DATA_WIDTH-1:0] loadData;

   always_comb begin
      inIllegal = (in_wen && in_ren)
               || (in_ren && !(in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
               || (in_wen && !(in_funct3 inside {3'b000, 3'b001, 3'b010}));
`ifdef YSYX_23060201_LSU_ALIGN_CHECK_EN
      inMisalign = (in_wen || in_ren)
                && (((in_funct3[1:0] == 2'b01) && in_addr[0])
                 || ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
`else
      inMisalign = 1'b0;
`endif
      inErr = inIllegal || inMisalign;
   end

   // Lane offset actually used: words ignore it, halves only honour the upper bit.
   // When misalignment traps, aligned accesses give the same value as the raw offset.
   always_comb begin
      case (funct3_q[1:0])
         2'b10:   effOff = 2'b00;
         2'b01:   effOff = {addr_q[1], 1'b0};
         default: effOff = addr_q[1:0];
      endcase
   end

   always_comb begin
      loadShift = mem_rdata >> {effOff, 3'b000};
      case (funct3_q)
         3'b000:  loadData = {{(DATA_WIDTH-8){loadShift[7]}}, loadShift[7:0]};
         3'b100:  loadData = {{(DATA_WIDTH-8){1'b0}}, loadShift[7:0]};
         3'b001:  loadData = {{(DATA_WIDTH-16){loadShift[15]}}, loadShift[15:0]};
         3'b101:  loadData = {{(DATA_WIDTH-16){1'b0}}, loadShift[15:0]};
         default: loadData = loadShift;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (inErr)       state_d = RESP;
               else if (in_wen) state_d = STORE;
               else if (in_ren) state_d = LOAD;
               else             state_d = RESP;
            end
         end
         STORE:   state_d = RESP;
         LOAD:    state_d = WAIT;
         WAIT:    state_d = RESP;
         RESP:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request fields are captured on accept; the result register is cleared there so
   // stores, errors and pass-through requests all report zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  addr_q   <= in_addr;
                  wdata_q  <= in_wdata;
                  funct3_q <= in_funct3;
                  rd_q     <= in_rd;
                  err_q    <= inErr;
                  rdata_q  <= '0;
               end
            end
            WAIT: rdata_q <= loadData;
            RESP: begin
               if (out_ready) begin
                  err_q   <= 1'b0;
                  rdata_q <= '0;
                  rd_q    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory strobes decode straight from state so an async reset kills them at once.
   always_comb begin
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wmask = 8'h00;
      mem_ren   = 1'b0;
      mem_raddr = '0;
      case (state_q)
         STORE: begin
            mem_wen   = 1'b1;
            mem_waddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata = wdata_q << {effOff, 3'b000};
            case (funct3_q[1:0])
               2'b00:   mem_wmask = 8'h01 << effOff;
               2'b01:   mem_wmask = 8'h03 << effOff;
               default: mem_wmask = 8'h0F;
            endcase
         end
         LOAD: begin
            mem_ren   = 1'b1;
            mem_raddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
         end
         default: ;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == RESP);
   assign out_rdata = rdata_q;
   assign out_rd    = rd_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for ysyx_23060201_lsu: a vector table of single requests plus
// hand-written backpressure and reset-during-load sequences.
module tb_ysyx_23060201_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_wen = 1'b0;
   logic        in_ren = 1'b0;
   logic [2:0]  in_funct3 = 3'b000;
   logic [31:0] in_addr = '0;
   logic [31:0] in_wdata = '0;
   logic [4:0]  in_rd = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rdata;
   logic [4:0]  out_rd;
   logic        out_err;
   logic        mem_wen;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata = '0;

   int passCount = 0;
   int totalCount = 0;

   ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_ren(in_ren),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_rd(out_rd), .out_err(out_err),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        wen;
      logic        ren;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        eErr;
      int          eLat;
      logic [31:0] eRdata;
      int          eWen;
      int          eRen;
      logic [31:0] eAddr;
      logic [31:0] eWdata;
      logic [7:0]  eMask;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // One request with out_ready held high; strobes and response are captured at negedges.
   task automatic applyStimulus(input vec_t v);
      int          wenCnt = 0;
      int          renCnt = 0;
      int          lat = 0;
      logic [31:0] sAddr = '0;
      logic [31:0] sData = '0;
      logic [7:0]  sMask = '0;
      logic [31:0] rRdata = '0;
      logic        rErr = 1'b0;
      logic [4:0]  rRd = '0;
      in_valid  = 1'b1;
      in_wen    = v.wen;
      in_ren    = v.ren;
      in_funct3 = v.f3;
      in_addr   = v.addr;
      in_wdata  = v.wdata;
      in_rd     = v.rd;
      mem_rdata = v.rdata;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_wen   = 1'b0;
      in_ren   = 1'b0;
      in_rd    = '0;
      in_addr  = '0;
      in_wdata = '0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         if (mem_wen) begin
            wenCnt++;
            sAddr = mem_waddr;
            sData = mem_wdata;
            sMask = mem_wmask;
         end
         if (mem_ren) begin
            renCnt++;
            sAddr = mem_raddr;
         end
         if (out_valid) begin
            lat    = c;
            rRdata = out_rdata;
            rErr   = out_err;
            rRd    = out_rd;
         end
      end
      checkOutput({v.name, " latency"}, lat, v.eLat);
      checkOutput({v.name, " out_err"}, {31'b0, rErr}, {31'b0, v.eErr});
      checkOutput({v.name, " out_rdata"}, rRdata, v.eRdata);
      checkOutput({v.name, " out_rd"}, {27'b0, rRd}, {27'b0, v.rd});
      checkOutput({v.name, " wen pulses"}, wenCnt, v.eWen);
      checkOutput({v.name, " ren pulses"}, renCnt, v.eRen);
      checkOutput({v.name, " mem addr"}, sAddr, v.eAddr);
      checkOutput({v.name, " mem wdata"}, sData, v.eWdata);
      checkOutput({v.name, " mem wmask"}, {24'b0, sMask}, {24'b0, v.eMask});
      @(posedge clk);
      #1;
   endtask

   task automatic waitValid(input string name);
      int seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      checkOutput({name, " out_valid seen"}, seen, 1);
   endtask

   initial begin
      //        name      wen  ren  f3    addr          wdata         rd     rdata         err lat eRdata        wen ren eAddr         eWdata        eMask
      vecs.push_back('{"sb_off3", 1, 0, 3'b000, 32'h80000003, 32'h12345678, 5'd5, 32'h0, 0, 2, 32'h0, 1, 0, 32'h80000000, 32'h78000000, 8'h08});
      vecs.push_back('{"lh_off2", 0, 1, 3'b001, 32'h80000002, 32'h0, 5'd6, 32'h80011234, 0, 3, 32'hFFFF8001, 0, 1, 32'h80000000, 32'h0, 8'h00});
      vecs.push_back('{"lhu_off2", 0, 1, 3'b101, 32'h80000002, 32'h0, 5'd7, 32'h80011234, 0, 3, 32'h00008001, 0, 1, 32'h80000000, 32'h0, 8'h00});
      vecs.push_back('{"lbu_off1", 0, 1, 3'b100, 32'h80000001, 32'h0, 5'd8, 32'h0000AB00, 0, 3, 32'h000000AB, 0, 1, 32'h80000000, 32'h0, 8'h00});
      vecs.push_back('{"lb_off1", 0, 1, 3'b000, 32'h80000001, 32'h0, 5'd9, 32'h0000AB00, 0, 3, 32'hFFFFFFAB, 0, 1, 32'h80000000, 32'h0, 8'h00});
      vecs.push_back('{"lw_off0", 0, 1, 3'b010, 32'h80000004, 32'h0, 5'd10, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 0, 1, 32'h80000004, 32'h0, 8'h00});
`ifdef YSYX_23060201_LSU_ALIGN_CHECK_EN
      vecs.push_back('{"sw_off2", 1, 0, 3'b010, 32'h80000002, 32'hCAFEF00D, 5'd11, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 8'h00});
      vecs.push_back('{"lh_off1", 0, 1, 3'b001, 32'h80000001, 32'h0, 5'd12, 32'h11223344, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 8'h00});
`else
      vecs.push_back('{"sw_off2", 1, 0, 3'b010, 32'h80000002, 32'hCAFEF00D, 5'd11, 32'h0, 0, 2, 32'h0, 1, 0, 32'h80000000, 32'hCAFEF00D, 8'h0F});
      vecs.push_back('{"lh_off1", 0, 1, 3'b001, 32'h80000001, 32'h0, 5'd12, 32'h11223344, 0, 3, 32'h00003344, 0, 1, 32'h80000000, 32'h0, 8'h00});
`endif
      vecs.push_back('{"sh_off2", 1, 0, 3'b001, 32'h80000002, 32'h0000BEEF, 5'd13, 32'h0, 0, 2, 32'h0, 1, 0, 32'h80000000, 32'hBEEF0000, 8'h0C});
      vecs.push_back('{"sb_off0", 1, 0, 3'b000, 32'h80000010, 32'hAABBCCDD, 5'd14, 32'h0, 0, 2, 32'h0, 1, 0, 32'h80000010, 32'hAABBCCDD, 8'h01});
      vecs.push_back('{"lb_off3", 0, 1, 3'b000, 32'h80000007, 32'h0, 5'd15, 32'h80FFFFFF, 0, 3, 32'hFFFFFF80, 0, 1, 32'h80000004, 32'h0, 8'h00});
      vecs.push_back('{"lbu_off2", 0, 1, 3'b100, 32'h80000006, 32'h0, 5'd16, 32'h00FF0000, 0, 3, 32'h000000FF, 0, 1, 32'h80000004, 32'h0, 8'h00});
      vecs.push_back('{"wen_ren", 1, 1, 3'b010, 32'h80000000, 32'h1, 5'd18, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 8'h00});
      vecs.push_back('{"ld_f3_3", 0, 1, 3'b011, 32'h80000000, 32'h0, 5'd19, 32'h5, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 8'h00});
      vecs.push_back('{"st_f3_4", 1, 0, 3'b100, 32'h80000000, 32'h5, 5'd20, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 8'h00});
      vecs.push_back('{"passthru", 0, 0, 3'b010, 32'h80000000, 32'h5, 5'd21, 32'h77, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 8'h00});

      // Reset state while rst_n is held low.
      #12;
      checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset mem_wen", {31'b0, mem_wen}, 32'd0);
      checkOutput("reset mem_ren", {31'b0, mem_ren}, 32'd0);
      checkOutput("reset out_err", {31'b0, out_err}, 32'd0);
      checkOutput("reset out_rdata", out_rdata, 32'd0);
      checkOutput("reset out_rd", {27'b0, out_rd}, 32'd0);
      checkOutput("reset mem_wmask", {24'b0, mem_wmask}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Backpressure: response and outputs must hold while out_ready is low, and a new
      // request presented during RESP must not be taken.
      begin
         int strobes = 0;
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_wen    = 1'b0;
         in_ren    = 1'b1;
         in_funct3 = 3'b010;
         in_addr   = 32'h80000008;
         in_rd     = 5'd17;
         mem_rdata = 32'h01020304;
         @(posedge clk);
         #1;
         in_ren   = 1'b0;
         in_wen   = 1'b1;
         in_addr  = 32'h80000020;
         in_wdata = 32'hFFFFFFFF;
         in_rd    = 5'd3;
         waitValid("bp");
         mem_rdata = 32'h99999999;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_wen || mem_ren) strobes++;
            checkOutput("bp out_valid held", {31'b0, out_valid}, 32'd1);
            checkOutput("bp out_rdata held", out_rdata, 32'h01020304);
            checkOutput("bp out_rd held", {27'b0, out_rd}, 32'd17);
            checkOutput("bp in_ready low", {31'b0, in_ready}, 32'd0);
         end
         in_valid  = 1'b0;
         in_wen    = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_wen || mem_ren) strobes++;
         end
         checkOutput("bp after out_valid", {31'b0, out_valid}, 32'd0);
         checkOutput("bp after in_ready", {31'b0, in_ready}, 32'd1);
         checkOutput("bp extra strobes", strobes, 0);
      end

      // Reset asserted while the read strobe is up drops the load entirely.
      begin
         int responses = 0;
         in_valid  = 1'b1;
         in_ren    = 1'b1;
         in_funct3 = 3'b000;
         in_addr   = 32'h80000000;
         in_rd     = 5'd22;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_ren   = 1'b0;
         @(negedge clk);
         checkOutput("rst mem_ren before", {31'b0, mem_ren}, 32'd1);
         #1;
         rst_n = 1'b0;
         #1;
         checkOutput("rst mem_ren killed", {31'b0, mem_ren}, 32'd0);
         checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid || mem_ren || mem_wen) responses++;
         end
         checkOutput("rst in_ready after", {31'b0, in_ready}, 32'd1);
         checkOutput("rst no response", responses, 0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
